// File: rtl/praxos_mbox_pkg.sv
// praxos_mbox_pkg: address map and bit indices shared by the Praxos mailbox bridge.
package praxos_mbox_pkg;
  localparam logic [5:0] A_IRQ_OUT = 6'd0;
  localparam logic [5:0] A_IRQ_IN = 6'd1;
  localparam logic [5:0] A_PM_LO = 6'd2;
  localparam logic [5:0] A_PM_HI = 6'd3;
  localparam logic [5:0] A_PM_ADDR = 6'd4;
  localparam logic [5:0] A_PM_WR = 6'd5;
  localparam logic [5:0] A_CTRL = 6'd6;
  localparam logic [5:0] A_STAT = 6'd7;
  localparam logic [5:0] A_MBOX = 6'd8;
  localparam int A_GP_BASE = 32;
  localparam int C_RUN = 0;
  localparam int C_AINC = 1;
  localparam int C_H2P_FLUSH = 2;
  localparam int C_P2H_FLUSH = 3;
  localparam int C_IEN = 4;
  localparam int S_H2P_EMPTY = 0;
  localparam int S_H2P_FULL = 1;
  localparam int S_P2H_EMPTY = 2;
  localparam int S_P2H_FULL = 3;
  localparam int S_H2P_OVF = 4;
  localparam int S_P2H_UNF = 5;
endpackage

// File: rtl/praxos_mbox_fifo.sv
// praxos_mbox_fifo: synchronous FIFO with flush; head data reads 0 when empty.
module praxos_mbox_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  // a pop frees a slot, so a full FIFO still takes a same-cycle push
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/praxos_mbox_ctrl.sv
// praxos_mbox_ctrl: Wishbone host bridge for Praxos (GP regs, PM write path, IRQs, mailboxes).
// Define PRAXOS_IRQ_IN_EDGE_EN to turn IRQ_IN into sticky rising-edge latches.
module praxos_mbox_ctrl
  import praxos_mbox_pkg::*;
#(
  parameter int NUM_GP = 16,
  parameter int PM_ADDR_W = 8,
  parameter int PM_DATA_W = 36,
  parameter int MBOX_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           wb_adr,
  input  logic [31:0]          wb_dat_w,
  output logic [31:0]          wb_dat_r,
  input  logic [3:0]           wb_sel,
  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  output logic                 wb_ack,
  output logic                 wb_stall,
  output logic                 wb_err,
  input  logic [31:0]          irq_in,
  output logic                 irq_out,
  output logic                 praxos_rst_n,
  output logic [PM_ADDR_W-1:0] praxos_pm_wr_addr,
  output logic                 praxos_pm_wr,
  output logic [PM_DATA_W-1:0] praxos_pm_wr_data,
  input  logic [5:0]           praxos_port_addr,
  input  logic                 praxos_port_rd,
  input  logic                 praxos_port_wr,
  input  logic [31:0]          praxos_port_wr_data,
  output logic [31:0]          praxos_port_rd_data
);
  localparam int CW = $clog2(MBOX_DEPTH) + 1;
  logic wb_wr, wb_rd, wb_req, unused;
  logic [31:0] irq_r, irq_in_q, irq_in_v, irq_set, irq_clr, pm_lo, wb_rdata, prd, stat, h2p_dout, p2h_dout;
  logic [PM_DATA_W-33:0] pm_hi;
  logic [PM_ADDR_W-1:0] pm_addr;
  logic ctrl_run, ctrl_ainc, ctrl_ien, ovf, unf;
  logic [31:0] gp [32];
  logic h2p_push, h2p_pop, h2p_flush, h2p_empty, h2p_full;
  logic p2h_push, p2h_pop, p2h_flush, p2h_empty, p2h_full;
  logic [CW-1:0] h2p_cnt, p2h_cnt;
  assign wb_req = wb_cyc & wb_stb;
  assign wb_wr = wb_req & wb_we;
  assign wb_rd = wb_req & ~wb_we;
  assign wb_stall = 1'b0;
  assign wb_err = 1'b0;
  assign unused = ^wb_sel;
  assign praxos_rst_n = ctrl_run;
  assign praxos_pm_wr_addr = pm_addr;
  assign praxos_pm_wr_data = {pm_hi, pm_lo};
  assign irq_set = (praxos_port_wr && praxos_port_addr == A_IRQ_OUT) ? praxos_port_wr_data : '0;
  assign irq_clr = (wb_wr && wb_adr == A_IRQ_OUT) ? wb_dat_w : '0;
  assign h2p_push = wb_wr && wb_adr == A_MBOX;
  assign p2h_pop = wb_rd && wb_adr == A_MBOX;
  assign h2p_pop = praxos_port_rd && praxos_port_addr == A_MBOX;
  assign p2h_push = praxos_port_wr && praxos_port_addr == A_MBOX;
  assign h2p_flush = wb_wr && wb_adr == A_CTRL && wb_dat_w[C_H2P_FLUSH];
  assign p2h_flush = wb_wr && wb_adr == A_CTRL && wb_dat_w[C_P2H_FLUSH];
  praxos_mbox_fifo #(.DEPTH(MBOX_DEPTH), .W(32)) u_h2p (
    .clk, .rst_n, .push(h2p_push), .pop(h2p_pop), .flush(h2p_flush), .din(wb_dat_w),
    .dout(h2p_dout), .count(h2p_cnt), .empty(h2p_empty), .full(h2p_full)
  );
  praxos_mbox_fifo #(.DEPTH(MBOX_DEPTH), .W(32)) u_p2h (
    .clk, .rst_n, .push(p2h_push), .pop(p2h_pop), .flush(p2h_flush), .din(praxos_port_wr_data),
    .dout(p2h_dout), .count(p2h_cnt), .empty(p2h_empty), .full(p2h_full)
  );
`ifdef PRAXOS_IRQ_IN_EDGE_EN
  logic [31:0] irq_in_q2, irq_lat;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_in_q2 <= '0;
      irq_lat <= '0;
    end else begin
      irq_in_q2 <= irq_in_q;
      irq_lat <= (irq_lat & ~((wb_wr && wb_adr == A_IRQ_IN) ? wb_dat_w : '0)) | (irq_in_q & ~irq_in_q2);
    end
  end
  assign irq_in_v = irq_lat;
`else
  assign irq_in_v = irq_in_q;
`endif
  always_comb begin
    stat = '0;
    stat[S_H2P_EMPTY] = h2p_empty;
    stat[S_H2P_FULL] = h2p_full;
    stat[S_P2H_EMPTY] = p2h_empty;
    stat[S_P2H_FULL] = p2h_full;
    stat[S_H2P_OVF] = ovf;
    stat[S_P2H_UNF] = unf;
    stat[15:8] = 8'(h2p_cnt);
    stat[23:16] = 8'(p2h_cnt);
  end
  always_comb begin
    wb_rdata = '0;
    case (wb_adr)
      A_IRQ_OUT: wb_rdata = irq_r;
      A_IRQ_IN: wb_rdata = irq_in_v;
      A_PM_LO: wb_rdata = pm_lo;
      A_PM_HI: wb_rdata = 32'(pm_hi);
      A_PM_ADDR: wb_rdata = 32'(pm_addr);
      A_CTRL: wb_rdata = 32'({ctrl_ien, 2'b00, ctrl_ainc, ctrl_run});
      A_STAT: wb_rdata = stat;
      A_MBOX: wb_rdata = p2h_dout;
      default: if (wb_adr[5] && 32'(wb_adr[4:0]) < NUM_GP) wb_rdata = gp[wb_adr[4:0]];
    endcase
  end
  always_comb begin
    prd = '0;
    case (praxos_port_addr)
      A_IRQ_OUT: prd = irq_r;
      A_IRQ_IN: prd = irq_in_v;
      A_STAT: prd = stat;
      A_MBOX: prd = h2p_dout;
      default: if (praxos_port_addr[5] && 32'(praxos_port_addr[4:0]) < NUM_GP) prd = gp[praxos_port_addr[4:0]];
    endcase
  end
  assign praxos_port_rd_data = praxos_port_rd ? prd : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_ack <= 1'b0;
      wb_dat_r <= '0;
      irq_in_q <= '0;
      irq_r <= '0;
      irq_out <= 1'b0;
      praxos_pm_wr <= 1'b0;
      pm_lo <= '0;
      pm_hi <= '0;
      pm_addr <= '0;
      {ctrl_ien, ctrl_ainc, ctrl_run} <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      for (int i = 0; i < 32; i++) gp[i] <= '0;
    end else begin
      wb_ack <= wb_req;
      wb_dat_r <= wb_rd ? wb_rdata : '0;
      irq_in_q <= irq_in;
      irq_r <= (irq_r & ~irq_clr) | irq_set;
      irq_out <= |irq_r | (ctrl_ien & ~p2h_empty);
      praxos_pm_wr <= wb_wr && wb_adr == A_PM_WR;
      if (wb_wr && wb_adr == A_PM_LO) pm_lo <= wb_dat_w;
      if (wb_wr && wb_adr == A_PM_HI) pm_hi <= wb_dat_w[PM_DATA_W-33:0];
      if (wb_wr && wb_adr == A_PM_ADDR) pm_addr <= wb_dat_w[PM_ADDR_W-1:0];
      else if (praxos_pm_wr && ctrl_ainc) pm_addr <= pm_addr + 1'b1;
      if (wb_wr && wb_adr == A_CTRL) {ctrl_ien, ctrl_ainc, ctrl_run} <= {wb_dat_w[C_IEN], wb_dat_w[C_AINC], wb_dat_w[C_RUN]};
      ovf <= (ovf & ~(wb_wr && wb_adr == A_STAT && wb_dat_w[S_H2P_OVF])) | (h2p_push & h2p_full & ~(h2p_pop & ~h2p_empty));
      unf <= (unf & ~(wb_wr && wb_adr == A_STAT && wb_dat_w[S_P2H_UNF])) | (p2h_pop & p2h_empty);
      // Praxos writes take priority over the host on the same GP register
      for (int i = 0; i < 32; i++)
        if (i >= NUM_GP) gp[i] <= '0;
        else if (praxos_port_wr && praxos_port_addr == 6'(A_GP_BASE + i)) gp[i] <= praxos_port_wr_data;
        else if (wb_wr && wb_adr == 6'(A_GP_BASE + i)) gp[i] <= wb_dat_w;
    end
  end
endmodule

// File: tb/tb_praxos_mbox_ctrl.sv
// tb_praxos_mbox_ctrl: scoreboard bench for the Praxos mailbox bridge (default parameters).
module tb_praxos_mbox_ctrl;
  logic clk = 0;
  logic rst_n = 0;
  logic [5:0] wb_adr = '0;
  logic [31:0] wb_dat_w = '0, wb_dat_r;
  logic [3:0] wb_sel = 4'hf;
  logic wb_cyc = 0, wb_stb = 0, wb_we = 0, wb_ack, wb_stall, wb_err;
  logic [31:0] irq_in = '0;
  logic irq_out, praxos_rst_n, praxos_pm_wr;
  logic [7:0] praxos_pm_wr_addr;
  logic [35:0] praxos_pm_wr_data;
  logic [5:0] praxos_port_addr = '0;
  logic praxos_port_rd = 0, praxos_port_wr = 0;
  logic [31:0] praxos_port_wr_data = '0, praxos_port_rd_data;
  int checks = 0, fails = 0;
  logic [63:0] sb[$];
  string tq[$];
  praxos_mbox_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
    .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack),
    .wb_stall(wb_stall), .wb_err(wb_err), .irq_in(irq_in), .irq_out(irq_out),
    .praxos_rst_n(praxos_rst_n), .praxos_pm_wr_addr(praxos_pm_wr_addr), .praxos_pm_wr(praxos_pm_wr),
    .praxos_pm_wr_data(praxos_pm_wr_data), .praxos_port_addr(praxos_port_addr),
    .praxos_port_rd(praxos_port_rd), .praxos_port_wr(praxos_port_wr),
    .praxos_port_wr_data(praxos_port_wr_data), .praxos_port_rd_data(praxos_port_rd_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wb_xfer(input logic we, input logic [5:0] a, input logic [31:0] d);
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = a; wb_dat_w = d;
    tick();
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    chk("ack", {63'b0, wb_ack}, 64'd1);
    if (!we) chk(tq.pop_front(), {32'b0, wb_dat_r}, sb.pop_front());
  endtask
  task automatic wb_write(input logic [5:0] a, input logic [31:0] d);
    wb_xfer(1, a, d);
  endtask
  task automatic wb_read(input logic [5:0] a, input logic [31:0] exp, input string tag);
    sb.push_back({32'b0, exp});
    tq.push_back(tag);
    wb_xfer(0, a, '0);
  endtask
  task automatic port_wr(input logic [5:0] a, input logic [31:0] d);
    praxos_port_addr = a; praxos_port_wr_data = d; praxos_port_wr = 1;
    tick();
    praxos_port_wr = 0;
  endtask
  task automatic port_rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
    sb.push_back({32'b0, exp});
    praxos_port_addr = a; praxos_port_rd = 1;
    #1;
    chk(tag, {32'b0, praxos_port_rd_data}, sb.pop_front());
    tick();
    praxos_port_rd = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {63'b0, wb_ack}, 0);
    chk("rst_prst", {63'b0, praxos_rst_n}, 0);
    chk("rst_irq", {63'b0, irq_out}, 0);
    chk("rst_pmwr", {63'b0, praxos_pm_wr}, 0);
    chk("rst_dat", {32'b0, wb_dat_r}, 0);
    rst_n = 1;
    tick();
    wb_write(6, 32'h1);
    chk("run", {63'b0, praxos_rst_n}, 1);
    wb_read(6, 32'h1, "ctrl");
    tick();
    chk("ack_low", {63'b0, wb_ack}, 0);
    // program-memory write path with auto-increment
    wb_write(2, 32'hDEADBEEF);
    wb_write(3, 32'hA);
    wb_write(4, 32'h10);
    wb_write(6, 32'h3);
    wb_write(5, 0);
    chk("pm_wr0", {63'b0, praxos_pm_wr}, 1);
    chk("pm_addr0", {56'b0, praxos_pm_wr_addr}, 64'h10);
    chk("pm_data", {28'b0, praxos_pm_wr_data}, 64'hADEADBEEF);
    wb_write(5, 0);
    chk("pm_wr1", {63'b0, praxos_pm_wr}, 1);
    chk("pm_addr1", {56'b0, praxos_pm_wr_addr}, 64'h11);
    tick();
    chk("pm_wr_end", {63'b0, praxos_pm_wr}, 0);
    wb_read(4, 32'h12, "pm_addr_rd");
    wb_read(3, 32'hA, "pm_hi_rd");
    wb_write(4, 32'hFF);
    wb_write(5, 0);
    chk("pm_addr_ff", {56'b0, praxos_pm_wr_addr}, 64'hFF);
    tick();
    wb_read(4, 32'h0, "pm_wrap");
    // H2P overflow, drain, underflow from Praxos side
    for (int i = 1; i <= 9; i++) wb_write(8, i);
    wb_read(7, 32'h816, "stat_full");
    for (int i = 1; i <= 8; i++) port_rd(8, i, "h2p_pop");
    wb_read(7, 32'h15, "stat_drained");
    port_rd(8, 0, "h2p_pop_empty");
    wb_write(7, 32'h10);
    // P2H with not-empty interrupt
    wb_write(6, 32'h11);
    port_wr(8, 32'h55);
    tick();
    chk("irq_p2h", {63'b0, irq_out}, 1);
    wb_read(8, 32'h55, "p2h_pop");
    tick();
    chk("irq_p2h_off", {63'b0, irq_out}, 0);
    wb_read(8, 32'h0, "p2h_pop_empty");
    wb_read(7, 32'h25, "stat_unf");
    wb_write(7, 32'h20);
    wb_read(7, 32'h05, "stat_unf_clr");
    // flush coinciding with a Praxos push
    port_wr(8, 32'h77);
    praxos_port_addr = 8; praxos_port_wr_data = 32'h88; praxos_port_wr = 1;
    wb_write(6, 32'h19);
    praxos_port_wr = 0;
    wb_read(7, 32'h05, "flush_push");
    wb_read(6, 32'h11, "ctrl_selfclr");
    // IRQ set beats W1C
    praxos_port_addr = 0; praxos_port_wr_data = 32'h1; praxos_port_wr = 1;
    wb_write(0, 32'h1);
    praxos_port_wr = 0;
    wb_read(0, 32'h1, "irq_set_wins");
    tick();
    chk("irq_out_on", {63'b0, irq_out}, 1);
    wb_write(0, 32'h1);
    tick();
    chk("irq_out_off", {63'b0, irq_out}, 0);
    wb_read(0, 32'h0, "irq_w1c");
    // GP registers
    praxos_port_addr = 35; praxos_port_wr_data = 32'h2; praxos_port_wr = 1;
    wb_write(35, 32'h1);
    praxos_port_wr = 0;
    wb_read(35, 32'h2, "gp_collide");
    port_rd(35, 32'h2, "gp_port_rd");
    wb_write(32, 32'h1234);
    port_rd(32, 32'h1234, "gp0_port");
    wb_write(48, 32'h5);
    wb_read(48, 32'h0, "gp_oob");
    wb_read(20, 32'h0, "unmapped");
    // simultaneous push/pop on H2P, non-empty then empty
    wb_write(8, 32'hA1);
    praxos_port_addr = 8; praxos_port_rd = 1;
    #1;
    chk("h2p_head", {32'b0, praxos_port_rd_data}, 64'hA1);
    wb_write(8, 32'hA2);
    praxos_port_rd = 0;
    wb_read(7, 32'h104, "stat_pushpop");
    port_rd(8, 32'hA2, "h2p_a2");
    praxos_port_addr = 8; praxos_port_rd = 1;
    #1;
    chk("h2p_empty_pp", {32'b0, praxos_port_rd_data}, 0);
    wb_write(8, 32'hB1);
    praxos_port_rd = 0;
    wb_read(7, 32'h104, "stat_empty_pp");
    port_rd(8, 32'hB1, "h2p_b1");
    // IRQ_IN
`ifdef PRAXOS_IRQ_IN_EDGE_EN
    irq_in = 32'h20;
    tick();
    irq_in = 0;
    repeat (3) tick();
    wb_read(1, 32'h20, "irq_in_edge");
    wb_write(1, 32'h20);
    wb_read(1, 32'h0, "irq_in_clr");
`else
    irq_in = 32'h20;
    tick();
    wb_read(1, 32'h20, "irq_in_lvl");
    irq_in = 0;
    tick();
    wb_read(1, 32'h0, "irq_in_low");
`endif
    // reset in the middle of a PM strobe with mailbox data pending
    wb_write(8, 32'h5);
    wb_write(5, 0);
    rst_n = 0;
    tick();
    chk("mid_rst_pmwr", {63'b0, praxos_pm_wr}, 0);
    chk("mid_rst_prst", {63'b0, praxos_rst_n}, 0);
    rst_n = 1;
    wb_read(7, 32'h05, "mid_rst_stat");
    port_rd(8, 0, "mid_rst_pop");
    wb_read(4, 32'h0, "mid_rst_pmaddr");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/praxos_mbox_ctrl.md
Name: praxos_mbox_ctrl

Overview:
- Next-generation Praxos controller/host bridge on the 32-bit pipelined Wishbone bus.
- Provides a parametrised GP register file, parametrised program-memory (PM) write path with address auto-increment, and IRQ set/ack.
- Adds two mailbox FIFOs: host->Praxos (H2P) and Praxos->host (P2H). They carry messages without polling GP registers.
- Sits between the WB crossbar and the Praxos core's PM write port and port-I/O bus.

Parameters:
- NUM_GP, 16: number of 32-bit GP registers (1..32).
- PM_ADDR_W, 8: PM address width.
- PM_DATA_W, 36: PM word width (33..64).
- MBOX_DEPTH, 8: entries per mailbox FIFO (power of 2, 2..256).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low; clock clk
- wb_adr  in  6  WB word address
- wb_dat_w  in  32  write data
- wb_dat_r  out  32  read data, registered
- wb_sel  in  4  ignored (full-word only)
- wb_cyc, wb_stb, wb_we  in  1  WB controls
- wb_ack  out  1  ack
- wb_stall  out  1  always 0
- wb_err  out  1  always 0
- irq_in  in  32  external IRQ lines
- irq_out  out  1  IRQ to host
- praxos_rst_n  out  1  Praxos reset
- praxos_pm_wr_addr  out  PM_ADDR_W  PM write address
- praxos_pm_wr  out  1  PM write strobe
- praxos_pm_wr_data  out  PM_DATA_W  PM write data
- praxos_port_addr  in  6  port address
- praxos_port_rd, praxos_port_wr  in  1  port strobes
- praxos_port_wr_data  in  32  port write data
- praxos_port_rd_data  out  32  port read data, combinational

Behaviour:
- Reset (rst_n=0 at a clk edge): all registers, FIFO pointers, sticky bits, wb_ack, wb_dat_r, praxos_pm_wr, PM addr/data and praxos_rst_n go to 0. Praxos is held in reset until CTRL[0] is set.
- WB handshake: wb_ack=1 exactly one cycle after each cyc&stb; wb_dat_r is valid in that ack cycle. Back-to-back strobes are acked back-to-back.
- WB map (word addr):
  - 0 IRQ_OUT: R, write-1-to-clear.
  - 1 IRQ_IN: R; irq_in registered once.
  - 2 PM_DATA_LO: RW.
  - 3 PM_DATA_HI: RW, bits [PM_DATA_W-33:0].
  - 4 PM_ADDR: RW.
  - 5 PM_WR: W; pulses praxos_pm_wr for 1 cycle the cycle after the write. If CTRL[1]=1, PM_ADDR increments by 1 in that same cycle and wraps at 2^PM_ADDR_W.
  - 6 CTRL: [0] praxos_rst_n, [1] autoinc, [2] H2P flush, [3] P2H flush, [4] P2H-not-empty IRQ enable. Bits 2 and 3 self-clear and read 0.
  - 7 MBOX_STAT: R/W1C. [0] H2P empty, [1] H2P full, [2] P2H empty, [3] P2H full, [4] H2P overflow sticky, [5] P2H underflow sticky (host popped empty), [15:8] H2P count, [23:16] P2H count. Only bits 4 and 5 are W1C.
  - 8 MBOX_DATA: W pushes H2P; R pops P2H.
  - 32..32+NUM_GP-1: GP registers, RW.
  - Unmapped addresses read 0; writes to them are ignored.
- Praxos port map:
  - 0: W sets IRQ_OUT bits.
  - 1: IRQ_IN.
  - 7: MBOX_STAT, read-only.
  - 8: W pushes P2H; R pops H2P.
  - 32+: GP registers, RW.
  - Read data is combinational from addr and is 0 when praxos_port_rd=0. A pop occurs on the clk edge where rd=1.
- irq_out = |IRQ_OUT | (CTRL[4] & !P2H empty), registered.
- FIFO boundaries:
  - Push when full: data dropped; H2P overflow sets sticky bit 4 (P2H drop sets nothing, Praxos must check full).
  - Pop when empty: returns 0, pointers unchanged; a host pop sets bit 5.
  - Push and pop in the same cycle on a non-empty FIFO: both happen, count unchanged.
  - Push and pop on an empty FIFO: pop returns 0, push accepted (no bypass).
  - Count reaches MBOX_DEPTH exactly when full.
- Collisions:
  - WB W1C and Praxos set of the same IRQ bit in one cycle: set wins.
  - WB and Praxos write the same GP register in one cycle: Praxos wins.
  - Flush coincident with a push: flush wins and the FIFO ends empty.
- Reset mid-operation clears FIFO contents and any pending PM strobe.

Optional Feature:
- Macro PRAXOS_IRQ_IN_EDGE_EN.
- Defined: register 1 becomes sticky rising-edge latches of the registered irq_in, W1C from WB, read-only from Praxos. An edge coinciding with a clear re-sets the bit.
- Undefined: register 1 is the level of irq_in delayed one cycle; writes are ignored.

Decomposition:
- Package praxos_mbox_pkg holds the WB/port address constants, CTRL/MBOX_STAT bit indices, and the GP base address (32).
- Sub-module praxos_mbox_fifo: synchronous FIFO with push, pop, flush, data, count, empty and full. It is instantiated twice.

Test Plan:
- Reset, write CTRL=0x1 -> praxos_rst_n=1 after ack; all other outputs 0; read CTRL=0x1.
- PM_DATA_LO=0xDEADBEEF, HI=0xA, ADDR=0x10, CTRL=0x3, two writes to PM_WR -> two 1-cycle pm_wr pulses at addrs 0x10 then 0x11, data 0xADEADBEEF; PM_ADDR reads 0x12. Also cover ADDR=0xFF wrapping to 0x00.
- Push 9 words into H2P with depth 8 -> STAT full=1, overflow=1, count=8. Praxos pops 8 -> 1..8 in order, then empty=1. A 9th Praxos pop returns 0.
- Praxos pushes 0x55 with CTRL[4]=1 -> irq_out=1; host reads MBOX_DATA -> 0x55, then irq_out=0. Host reading empty P2H -> 0 and STAT[5]=1; W1C of 0x20 clears it.
- Same cycle: WB W1C 0x1 to IRQ_OUT and Praxos sets 0x1 -> bit remains 1. Same-cycle GP[3] writes (WB 0x1, Praxos 0x2) -> reads 0x2.
- With PRAXOS_IRQ_IN_EDGE_EN: pulse irq_in[5] for 1 cycle -> reg1=0x20 persists; W1C 0x20 -> 0. Without the macro -> reg1 follows the level.
